comparator: RTL and testbench

COMPARATOR -- requirements
Module: comparator

---
 rtl/comparator_pkg.sv | 16 +
 rtl/comparator_slice.sv | 44 ++++
 rtl/comparator.sv | 87 ++++++++
 tb/tb_comparator.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/comparator_pkg.sv
// Shared definitions for the cascadable magnitude comparator: result encoding,
// default operand width and slice width.
package comparator_pkg;

    localparam int unsigned DEFAULT_WIDTH = 1;
    localparam int unsigned SLICE_W       = 4;

    // One-hot result, bit order {GT, EQ, LT} matches the h/e/l output order.
    typedef enum logic [2:0] {
        RES_NONE = 3'b000,
        RES_LT   = 3'b001,
        RES_EQ   = 3'b010,
        RES_GT   = 3'b100
    } cmp_res_e;

endpackage

// File: rtl/comparator_slice.sv
// Combinational 4-bit magnitude compare. Ties are resolved from the
// less-significant cascade inputs; the most-significant slice optionally
// applies the two's-complement correction.
module comparator_slice
    import comparator_pkg::*;
(
    input  logic [SLICE_W-1:0] a_i,
    input  logic [SLICE_W-1:0] b_i,
    input  logic               signed_i,
    input  logic               casc_h_i,
    input  logic               casc_l_i,
    output logic               h_o,
    output logic               e_o,
    output logic               l_o
);

    logic [SLICE_W-1:0] a_adj;
    logic [SLICE_W-1:0] b_adj;
    cmp_res_e           res;

    always_comb begin
        a_adj = a_i;
        b_adj = b_i;
        // Inverting the sign bits maps two's-complement order onto unsigned order.
        if (signed_i) begin
            a_adj[SLICE_W-1] = ~a_i[SLICE_W-1];
            b_adj[SLICE_W-1] = ~b_i[SLICE_W-1];
        end

        res = RES_EQ;
        if (a_adj > b_adj) begin
            res = RES_GT;
        end else if (a_adj < b_adj) begin
            res = RES_LT;
        end else if (casc_h_i) begin
            res = RES_GT;
        end else if (casc_l_i) begin
            res = RES_LT;
        end

        {h_o, e_o, l_o} = res;
    end

endmodule

// File: rtl/comparator.sv
// Registered cascadable comparator: operands are extended to whole nibbles,
// compared by a chain of 4-bit slices, and the one-hot result is registered.
module comparator
    import comparator_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    input  logic             casc_h,
    input  logic             casc_e,
    input  logic             casc_l,
    output logic             h,
    output logic             e,
    output logic             l,
    output logic             out_valid
);

    localparam int unsigned NSLICE = (WIDTH + SLICE_W - 1) / SLICE_W;
    localparam int unsigned EXT_W  = NSLICE * SLICE_W;

    logic [EXT_W-1:0]  a_ext;
    logic [EXT_W-1:0]  b_ext;
    logic [NSLICE:0]   ch_h;
    logic [NSLICE:0]   ch_l;
    logic [NSLICE-1:0] ch_e;
    cmp_res_e          res_d;
    logic [2:0]        res_q;
    logic              vld_q;
    logic              unused_ok;

    always_comb begin
        if (SIGNED != 0) begin
            a_ext = EXT_W'($signed(a));
            b_ext = EXT_W'($signed(b));
        end else begin
            a_ext = EXT_W'(a);
            b_ext = EXT_W'(b);
        end
    end

    assign ch_h[0] = casc_h;
    assign ch_l[0] = casc_l;

    for (genvar g = 0; g < NSLICE; g++) begin : g_slice
        comparator_slice u_slice (
            .a_i      (a_ext[g*SLICE_W +: SLICE_W]),
            .b_i      (b_ext[g*SLICE_W +: SLICE_W]),
            .signed_i ((SIGNED != 0) && (g == NSLICE - 1)),
            .casc_h_i (ch_h[g]),
            .casc_l_i (ch_l[g]),
            .h_o      (ch_h[g+1]),
            .e_o      (ch_e[g]),
            .l_o      (ch_l[g+1])
        );
    end

    // An equal compare with neither casc_h nor casc_l already resolves to EQ,
    // so casc_e and the lower slices' equal flags carry no extra information.
    assign unused_ok = ^{casc_e, ch_e};

    always_comb begin
        res_d = cmp_res_e'({ch_h[NSLICE], ch_e[NSLICE-1], ch_l[NSLICE]});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q <= '0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= in_valid;
            if (in_valid) begin
                res_q <= res_d;
            end
        end
    end

    assign h         = res_q[2];
    assign e         = res_q[1];
    assign l         = res_q[0];
    assign out_valid = vld_q;

endmodule

// File: tb/tb_comparator.sv
// Directed bench for comparator across several WIDTH/SIGNED configurations;
// results are checked as {out_valid, h, e, l}.
module tb_comparator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       a1, b1, v1;
    logic       h1u, e1u, l1u, o1u;
    logic       h1s, e1s, l1s, o1s;

    logic [7:0] a8, b8;
    logic       v8;
    logic       h8u, e8u, l8u, o8u;
    logic       h8s, e8s, l8s, o8s;

    logic [3:0] a4, b4;
    logic       v4, ch4, ce4, cl4;
    logic       h4, e4, l4, o4;

    logic [15:0] a16, b16;
    logic        v16;
    logic        h16, e16, l16, o16;

    int n_checks = 0;
    int n_pass   = 0;

    comparator #(.WIDTH(1), .SIGNED(0)) u_w1u (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(v1),
        .casc_h(1'b0), .casc_e(1'b1), .casc_l(1'b0),
        .h(h1u), .e(e1u), .l(l1u), .out_valid(o1u)
    );

    comparator #(.WIDTH(1), .SIGNED(1)) u_w1s (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(v1),
        .casc_h(1'b0), .casc_e(1'b1), .casc_l(1'b0),
        .h(h1s), .e(e1s), .l(l1s), .out_valid(o1s)
    );

    comparator #(.WIDTH(8), .SIGNED(0)) u_w8u (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .in_valid(v8),
        .casc_h(1'b0), .casc_e(1'b1), .casc_l(1'b0),
        .h(h8u), .e(e8u), .l(l8u), .out_valid(o8u)
    );

    comparator #(.WIDTH(8), .SIGNED(1)) u_w8s (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .in_valid(v8),
        .casc_h(1'b0), .casc_e(1'b1), .casc_l(1'b0),
        .h(h8s), .e(e8s), .l(l8s), .out_valid(o8s)
    );

    comparator #(.WIDTH(4), .SIGNED(0)) u_w4 (
        .clk(clk), .rst(rst), .a(a4), .b(b4), .in_valid(v4),
        .casc_h(ch4), .casc_e(ce4), .casc_l(cl4),
        .h(h4), .e(e4), .l(l4), .out_valid(o4)
    );

    comparator #(.WIDTH(16), .SIGNED(0)) u_w16 (
        .clk(clk), .rst(rst), .a(a16), .b(b16), .in_valid(v16),
        .casc_h(1'b0), .casc_e(1'b1), .casc_l(1'b0),
        .h(h16), .e(e16), .l(l16), .out_valid(o16)
    );

    task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got vhel=%b expected vhel=%b", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Stimulus tables: expected values are {out_valid, h, e, l}.
    logic [3:0] w1u_exp [4] = '{4'b1010, 4'b1001, 4'b1100, 4'b1010};
    logic [3:0] w1s_exp [4] = '{4'b1010, 4'b1100, 4'b1001, 4'b1010};

    logic [7:0] w8_a     [4] = '{8'hFF, 8'h80, 8'h7F, 8'hFE};
    logic [7:0] w8_b     [4] = '{8'h01, 8'h7F, 8'h80, 8'hFF};
    logic [3:0] w8u_exp  [4] = '{4'b1100, 4'b1100, 4'b1001, 4'b1001};
    logic [3:0] w8s_exp  [4] = '{4'b1001, 4'b1001, 4'b1100, 4'b1001};

    logic [3:0] w4_a     [7] = '{4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'h3, 4'hA};
    logic [3:0] w4_b     [7] = '{4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9};
    logic [2:0] w4_casc  [7] = '{3'b100, 3'b001, 3'b000, 3'b101, 3'b010, 3'b100, 3'b001};
    logic [3:0] w4_exp   [7] = '{4'b1100, 4'b1001, 4'b1010, 4'b1100, 4'b1010, 4'b1001, 4'b1100};

    logic [15:0] w16_a   [4] = '{16'h1234, 16'h8000, 16'h0000, 16'h00F0};
    logic [15:0] w16_b   [4] = '{16'h1234, 16'h7FFF, 16'hFFFF, 16'h00EF};
    logic [3:0]  w16_exp [4] = '{4'b1010, 4'b1100, 4'b1001, 4'b1100};

    initial begin
        rst = 1'b1;
        v1 = 1'b1; a1 = 1'b1; b1 = 1'b0;
        v8 = 1'b0; a8 = '0; b8 = '0;
        v4 = 1'b0; a4 = '0; b4 = '0; ch4 = 1'b0; ce4 = 1'b1; cl4 = 1'b0;
        v16 = 1'b0; a16 = '0; b16 = '0;

        for (int c = 0; c < 2; c++) begin
            step();
            check_eq($sformatf("rst_w1u_c%0d", c), {o1u, h1u, e1u, l1u}, 4'b0000);
            check_eq($sformatf("rst_w1s_c%0d", c), {o1s, h1s, e1s, l1s}, 4'b0000);
        end
        check_eq("rst_w8s", {o8s, h8s, e8s, l8s}, 4'b0000);
        check_eq("rst_w4",  {o4, h4, e4, l4},     4'b0000);
        check_eq("rst_w16", {o16, h16, e16, l16}, 4'b0000);

        rst = 1'b0;
        step();
        check_eq("post_rst_w1u", {o1u, h1u, e1u, l1u}, 4'b1100);
        check_eq("post_rst_w1s", {o1s, h1s, e1s, l1s}, 4'b1001);

        for (int i = 0; i < 4; i++) begin
            {a1, b1} = 2'(i);
            step();
            check_eq($sformatf("w1u_ab%0d", i), {o1u, h1u, e1u, l1u}, w1u_exp[i]);
            check_eq($sformatf("w1s_ab%0d", i), {o1s, h1s, e1s, l1s}, w1s_exp[i]);
        end
        v1 = 1'b0; a1 = 1'b0; b1 = 1'b1;
        step();
        check_eq("w1u_hold", {o1u, h1u, e1u, l1u}, 4'b0010);
        check_eq("w1s_hold", {o1s, h1s, e1s, l1s}, 4'b0010);

        v8 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a8 = w8_a[i];
            b8 = w8_b[i];
            step();
            check_eq($sformatf("w8u_%0d", i), {o8u, h8u, e8u, l8u}, w8u_exp[i]);
            check_eq($sformatf("w8s_%0d", i), {o8s, h8s, e8s, l8s}, w8s_exp[i]);
        end
        v8 = 1'b0;

        v4 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            a4 = w4_a[i];
            b4 = w4_b[i];
            {ch4, ce4, cl4} = w4_casc[i];
            step();
            check_eq($sformatf("w4_casc_%0d", i), {o4, h4, e4, l4}, w4_exp[i]);
        end
        v4 = 1'b0;

        v16 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a16 = w16_a[i];
            b16 = w16_b[i];
            step();
            check_eq($sformatf("w16_b2b_%0d", i), {o16, h16, e16, l16}, w16_exp[i]);
        end
        a16 = 16'h0000; b16 = 16'hFFFF;
        step();
        check_eq("w16_pre_idle", {o16, h16, e16, l16}, 4'b1001);
        v16 = 1'b0;
        a16 = 16'hFFFF; b16 = 16'h0000;
        for (int c = 0; c < 2; c++) begin
            step();
            check_eq($sformatf("w16_hold_c%0d", c), {o16, h16, e16, l16}, 4'b0001);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
